// File: rtl/div_sequencer_if.sv
// E-stage <-> divider handshake: request/operands toward the divider, stall and results back.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             annul_i;
  logic             stall_o;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, a_i, b_i, annul_i,
    input  stall_o, busy_o, ready_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, annul_i,
    output stall_o, busy_o, ready_o, hi_o, lo_o
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// magnitude datapath with sign fix-up applied when the result is registered.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          resetn,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvsr, hi, lo;
  logic             neg_q, neg_r;
  logic             accept, last;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, quo_nxt;
  logic [WIDTH:0]   rem_sh, trial;

  assign accept = (state == IDLE) && bus.start_i && !bus.annul_i;
  assign last   = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    a_mag  = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    b_mag  = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (bus.b_i == '0) ? DONE : BUSY;
      BUSY: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.annul_i) state_nxt = IDLE;
  end

  // Quotient shifts in from the bottom of the dividend register; the final
  // iteration's result is fixed up and registered on the way into DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= a_mag;
      dvsr  <= b_mag;
      neg_q <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
      neg_r <= bus.signed_i & bus.a_i[WIDTH-1];
      if (bus.b_i == '0) begin
        hi <= bus.a_i;
        lo <= '1;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      rem <= rem_nxt;
      quo <= quo_nxt;
      if (last && !bus.annul_i) begin
        hi <= neg_r ? -rem_nxt : rem_nxt;
        lo <= neg_q ? -quo_nxt : quo_nxt;
      end
    end
  end

  always_comb begin
    bus.stall_o = ((state == IDLE) && bus.start_i || (state == BUSY)) && !bus.annul_i;
    bus.busy_o  = (state == BUSY);
    bus.ready_o = (state == DONE) && !bus.annul_i;
    bus.hi_o    = hi;
    bus.lo_o    = lo;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: cycle-exact handshake checks plus a result scoreboard.
module tb_div_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] exp_pair;
  logic [W-1:0]   prev_hi = '0;
  logic [W-1:0]   prev_lo = '0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus.ready_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", W'(bus.ready_o), '0);
      end else begin
        exp_pair = sb.pop_front();
        chk("hi_result", bus.hi_o, exp_pair[2*W-1:W]);
        chk("lo_result", bus.lo_o, exp_pair[W-1:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int lat;
    lat = (b == '0) ? 1 : W + 1;
    cyc();
    bus.start_i = 1'b1; bus.signed_i = sgn; bus.a_i = a; bus.b_i = b; bus.annul_i = 1'b0;
    #2;
    chk("stall_accept", W'(bus.stall_o), 1);
    chk("hi_hold", bus.hi_o, prev_hi);
    chk("lo_hold", bus.lo_o, prev_lo);
    sb.push_back({exp_hi, exp_lo});
    for (int i = 1; i < lat; i++) begin
      cyc(); #2;
      chk("stall_busy", W'(bus.stall_o), 1);
      chk("busy_busy", W'(bus.busy_o), 1);
      chk("ready_busy", W'(bus.ready_o), 0);
    end
    cyc(); #2;
    chk("ready_done", W'(bus.ready_o), 1);
    chk("stall_done", W'(bus.stall_o), 0);
    chk("busy_done", W'(bus.busy_o), 0);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  task automatic idle_check(input string tag);
    cyc();
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    #2;
    chk({tag, "_busy"}, W'(bus.busy_o), 0);
    chk({tag, "_ready"}, W'(bus.ready_o), 0);
    chk({tag, "_stall"}, W'(bus.stall_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.annul_i = 1'b0;
    #2;
    chk("rst_stall", W'(bus.stall_o), 0);
    chk("rst_busy", W'(bus.busy_o), 0);
    chk("rst_ready", W'(bus.ready_o), 0);
    chk("rst_hi", bus.hi_o, 0);
    chk("rst_lo", bus.lo_o, 0);
    cyc(); cyc();
    resetn = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    run_div(1'b1, -32'sd100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    run_div(1'b1, 32'd100, -32'sd7, 32'd2, 32'hFFFF_FFF2);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
    run_div(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_div(1'b1, -32'sd7, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    idle_check("idle_after_dz");

    // start together with annul in IDLE must not be accepted
    cyc();
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.a_i = 32'd40; bus.b_i = 32'd6; bus.annul_i = 1'b1;
    #2;
    chk("stall_start_annul", W'(bus.stall_o), 0);
    idle_check("idle_start_annul");
    chk("hi_start_annul", bus.hi_o, prev_hi);
    chk("lo_start_annul", bus.lo_o, prev_lo);

    // annul mid-BUSY at relative cycle 10
    cyc();
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.a_i = 32'd50; bus.b_i = 32'd3; bus.annul_i = 1'b0;
    #2;
    chk("stall_accept_annul", W'(bus.stall_o), 1);
    for (int i = 1; i < 10; i++) cyc();
    cyc();
    bus.annul_i = 1'b1;
    #2;
    chk("stall_annul", W'(bus.stall_o), 0);
    chk("busy_annul", W'(bus.busy_o), 1);
    idle_check("idle_after_annul");
    chk("hi_after_annul", bus.hi_o, prev_hi);
    chk("lo_after_annul", bus.lo_o, prev_lo);
    run_div(1'b0, 32'd9, 32'd2, 32'd1, 32'd4);

    // asynchronous reset in BUSY relative cycle 20
    cyc();
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.a_i = 32'd50; bus.b_i = 32'd3; bus.annul_i = 1'b0;
    for (int i = 1; i < 20; i++) cyc();
    cyc(); #2;
    chk("busy_before_rst", W'(bus.busy_o), 1);
    bus.start_i = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_stall", W'(bus.stall_o), 0);
    chk("mid_rst_busy", W'(bus.busy_o), 0);
    chk("mid_rst_ready", W'(bus.ready_o), 0);
    chk("mid_rst_hi", bus.hi_o, 0);
    chk("mid_rst_lo", bus.lo_o, 0);
    cyc();
    resetn = 1'b1;
    prev_hi = '0;
    prev_lo = '0;
    run_div(1'b0, 32'd7, 32'd7, 32'd0, 32'd1);

    for (int k = 0; k < 3; k++) begin
      ra = $urandom;
      rb = (k == 2) ? ($urandom | 32'h0001_0000) : $urandom_range(1, 1000);
      run_div(1'b0, ra, rb, ra % rb, ra / rb);
    end
    idle_check("idle_final");
    cyc(); cyc();
    chk("sb_empty", W'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle signed/unsigned divider with its own sequencing FSM, shared by DIV/DIVU in the execute stage of the 5-stage MIPS pipeline.
- Accepts a start pulse from the E stage and raises a stall to the hazard unit while iterating.
- Delivers remainder/quotient for the HI/LO write, and can be annulled by an exception/flush at any point.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- start_i  in  1  E-stage div request; held high while the instruction sits in E.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- a_i  in  WIDTH  dividend; sampled with start_i.
- b_i  in  WIDTH  divisor; sampled with start_i.
- annul_i  in  1  flushE / exception cancel.
- stall_o  out  1  stall request to the hazard unit.
- busy_o  out  1  high in BUSY.
- ready_o  out  1  one-cycle result-valid strobe.
- hi_o  out  WIDTH  remainder.
- lo_o  out  WIDTH  quotient.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State goes to IDLE; counter = 0.
  - stall_o, busy_o and ready_o = 0; hi_o = lo_o = 0; internal operand registers = 0.
- States: IDLE, BUSY, DONE.
- IDLE, when start_i & ~annul_i:
  - stall_o = 1 combinationally in this same cycle.
  - Latch |a| and |b| (raw values if signed_i = 0), the dividend sign, the quotient sign (sa^sb), and signed_i.
  - Clear the partial remainder; counter = 0.
  - If b_i == 0, go to DONE with hi = a_i, lo = all-ones, and no sign fix-up. Otherwise go to BUSY.
- BUSY (restoring division), once per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor (WIDTH+1 bits).
  - If trial is non-negative: rem = trial and quo[0] = 1; else quo[0] = 0.
  - Counter increments each cycle. After the iteration with counter == WIDTH-1, go to DONE.
  - Exactly WIDTH BUSY cycles. stall_o = 1 and busy_o = 1 throughout.
- DONE:
  - ready_o = 1 and stall_o = 0 for exactly one cycle, then IDLE.
  - Signed fix-up: lo = negate(quo) if the quotient sign is 1; hi = negate(rem) if the dividend sign is 1.
  - hi_o/lo_o are registered and stable from the DONE cycle until the next accepted start.
  - start_i is ignored in DONE; a new request is accepted only from IDLE.
- Latency: start_i accepted in cycle t gives BUSY t+1..t+WIDTH, DONE/ready_o at t+WIDTH+1. stall_o is high for cycles t..t+WIDTH (WIDTH+1 cycles).
- Divide-by-zero: start at t gives DONE at t+1; stall_o is high in cycle t only.
- annul_i:
  - In any state, annul_i forces IDLE on the next edge and forces stall_o = 0 combinationally in that cycle.
  - ready_o is never asserted for an annulled operation, and hi_o/lo_o keep their previous values.
  - annul_i together with start_i in IDLE: the start is not accepted.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (wraps, no trap).
- Back-to-back divides: a second start_i in cycle t+WIDTH+2 (IDLE) is accepted normally.
- Widths: all negations are modulo 2^WIDTH; |0x80000000| = 0x80000000 is treated as unsigned magnitude.
- Reset asserted mid-BUSY: the operation is aborted immediately, with no ready_o.

Test Plan:
- DIVU 100/7, start at cycle 0 -> stall_o high cycles 0..32; ready_o at cycle 33 only; lo = 14, hi = 2.
- DIV -100/7 -> lo = 0xFFFFFFF2 (-14), hi = 0xFFFFFFFE (-2). DIV 100/-7 -> lo = -14, hi = 2.
- DIV 0x80000000/0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU 0xFFFFFFFF/1 -> lo = 0xFFFFFFFF, hi = 0.
- DIVU 5/0 -> ready_o at cycle 1, hi = 5, lo = 0xFFFFFFFF; stall_o high only in cycle 0.
- DIVU 50/3 started, annul_i at cycle 10 -> stall_o = 0 at cycle 10; IDLE at 11; no ready_o; hi/lo unchanged. A new DIVU 9/2 at 12 -> ready_o at 45, lo = 4, hi = 1.
- resetn pulled low at cycle 20 of a BUSY op -> all outputs 0 asynchronously. After release, start 7/7 -> lo = 1, hi = 0 after 33 cycles.
